// File: rtl/exc_pkg.sv
// Shared types and cause-code definitions for the exception/interrupt controller.
package exc_pkg;

  // Controller phases: waiting, requesting a vector, running the handler.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } excState_e;

  // EStatus cause codes.
  localparam int unsigned ES_NONE     = 0;
  localparam int unsigned ES_INVOP    = 1;
  localparam int unsigned ES_IRQ_BASE = 2;

  // Cause code reported for external channel ch.
  function automatic int unsigned irqCode(input int unsigned ch);
    return ES_IRQ_BASE + ch;
  endfunction

endpackage

// File: rtl/exc_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder used for interrupt channel arbitration.
module prio_enc #(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception / interrupt controller: edge-latched IRQ channels with a mask,
// a REQ -> HANDLER -> IDLE vectoring handshake and a sticky double-fault flag.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     irq_i,
  input  logic                 mask_we,
  input  logic [N_IRQ-1:0]     mask_wdata,
  input  logic                 exc_i,
  input  logic                 exc_ack_i,
  input  logic                 eret_i,
  output logic                 exc_o,
  output logic [ESTATUS_W-1:0] estatus_o,
  output logic [N_IRQ-1:0]     irq_ack_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [N_IRQ-1:0]     mask_o
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  generate
    if (N_IRQ < 1 || N_IRQ > 14) begin : gBadNIrq
      $error("exc_irq_ctrl: N_IRQ must be in 1..14");
    end
    if ((2 ** ESTATUS_W) < N_IRQ + 2) begin : gBadEsW
      $error("exc_irq_ctrl: ESTATUS_W too narrow for N_IRQ+2 cause codes");
    end
  endgenerate

  excState_e            state, stateNext;
  logic [ESTATUS_W-1:0] cause, causeNext;
  logic [N_IRQ-1:0]     reqVec, reqVecNext;
  logic [N_IRQ-1:0]     ackNext, irqAck;
  logic [N_IRQ-1:0]     irqPrev, pending, mask;
  logic [N_IRQ-1:0]     edges, armed;
  logic [IDX_W-1:0]     winIdx;
  logic                 winValid;
  logic                 fault;

  assign edges = irq_i & ~irqPrev;
  assign armed = pending & mask;

  prio_enc #(.WIDTH(N_IRQ)) uPrioEnc (
    .req  (armed),
    .idx  (winIdx),
    .valid(winValid)
  );

  // Next-state and cause selection; the internal exception outranks every channel.
  always_comb begin
    stateNext  = state;
    causeNext  = cause;
    reqVecNext = reqVec;
    ackNext    = '0;
    case (state)
      IDLE: begin
        if (exc_i) begin
          stateNext  = REQ;
          causeNext  = ESTATUS_W'(ES_INVOP);
          reqVecNext = '0;
        end else if (winValid) begin
          stateNext  = REQ;
          causeNext  = ESTATUS_W'(irqCode(32'(winIdx)));
          reqVecNext = N_IRQ'(1) << winIdx;
        end
      end
      REQ: begin
        if (exc_ack_i) begin
          stateNext = HANDLER;
          ackNext   = reqVec;
        end
      end
      HANDLER: begin
        if (eret_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Handshake state, latched cause/channel, registered acknowledge and fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cause  <= '0;
      reqVec <= '0;
      irqAck <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= stateNext;
      cause  <= causeNext;
      reqVec <= reqVecNext;
      irqAck <= ackNext;
      if (exc_i && state != IDLE) fault <= 1'b1;
    end
  end

  // Edge detection, pending latch (a new edge beats an acknowledge-clear) and mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqPrev <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      irqPrev <= irq_i;
      pending <= (pending & ~ackNext) | edges;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign exc_o     = (state == REQ);
  assign busy_o    = (state == HANDLER);
  assign estatus_o = (state == IDLE) ? ESTATUS_W'(ES_NONE) : cause;
  assign irq_ack_o = irqAck;
  assign fault_o   = fault;
  assign mask_o    = mask;

endmodule

// File: doc/exc_irq_ctrl.md
EXC_IRQ_CTRL -- requirements
Module: exc_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4: number of external interrupt channels, range 1..14.
REQ-002 Parameter ESTATUS_W, default 4: width of the EStatus code; 2**ESTATUS_W >= N_IRQ+2, checked at elaboration.
REQ-003 clk  in  1  single processor clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 irq_i  in  N_IRQ  external interrupt request lines, synchronous to clk; a rising edge requests service.
REQ-006 mask_we  in  1  write strobe for the mask register.
REQ-007 mask_wdata  in  N_IRQ  new mask value; 1 = channel enabled.
REQ-008 exc_i  in  1  internal exception (invalid opcode) from the decoder, level, valid for one cycle.
REQ-009 exc_ack_i  in  1  core has vectored to the handler (ExcAck from datapath).
REQ-010 eret_i  in  1  core executed ERET.
REQ-011 exc_o  out  1  exception request to the datapath (Exc).
REQ-012 estatus_o  out  ESTATUS_W  cause code (EStatus).
REQ-013 irq_ack_o  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced channel.
REQ-014 busy_o  out  1  handler in progress.
REQ-015 fault_o  out  1  sticky double-fault flag.
REQ-016 mask_o  out  N_IRQ  current mask register.

Function
REQ-017 A rising edge on irq_i[k] (low at previous sample, high at current) sets pending[k] at that clock edge, regardless of mask or state.
REQ-018 Pending bits are cleared only by acknowledge (REQ-023) or reset; if a new edge and the acknowledge-clear coincide on the same channel, the set wins.
REQ-019 mask_we loads mask_wdata into the mask at the clock edge; it takes effect for arbitration from the next cycle.
REQ-020 FSM states: IDLE, REQ, HANDLER.
REQ-021 IDLE: exc_i=1 -> REQ with cause = internal; else any (pending & mask) nonzero -> REQ with cause = lowest-index enabled pending channel; else stay. exc_i has priority over all channels in the same cycle.
REQ-022 REQ: exc_o=1, estatus_o held constant; cause is latched on entry and not withdrawn by later mask or pending changes.
REQ-023 REQ with exc_ack_i=1 -> HANDLER; in that cycle irq_ack_o[k]=1 for the latched channel k only (all zero for internal cause), and pending[k] clears at that edge.
REQ-024 HANDLER: busy_o=1, exc_o=0, estatus_o held; new edges still set pending; no new request issued; eret_i=1 -> IDLE.
REQ-025 exc_i=1 in REQ or HANDLER sets fault_o=1 (sticky until reset); state and cause are unchanged.
REQ-026 eret_i outside HANDLER and exc_ack_i outside REQ are ignored.
REQ-027 EStatus codes: 0 = none, 1 = invalid opcode, 2+k = IRQ channel k; estatus_o = 0 in IDLE.
REQ-028 Latency: an IRQ edge sampled at edge t sets pending at t, enters REQ at t+1, so exc_o is high in the cycle after t+1; exc_i sampled at edge t enters REQ at t, so exc_o is high in the cycle after t.
REQ-029 irq_ack_o is registered and asserted only in the cycle following the acknowledging edge; exc_o, busy_o and estatus_o decode from registered state.

Reset
REQ-030 While reset=0: state=IDLE, pending=0, mask=all ones, previous-irq samples=0, fault_o=0, exc_o=0, estatus_o=0, irq_ack_o=0, busy_o=0.
REQ-031 Reset asserted mid-request or mid-handler aborts immediately, with no acknowledge pulse; after release, edges must reoccur to be serviced.

Structure
REQ-032 Package exc_pkg holds the state enum, EStatus code constants (ES_NONE, ES_INVOP, ES_IRQ_BASE) and a function mapping channel index to code.
REQ-033 One sub-module prio_enc (parameter WIDTH) returns lowest-set-bit index plus a valid flag; it is used for channel arbitration.

Verification
REQ-034 Reset, then irq_i[2] 0->1 -> exc_o=1 two cycles later, estatus_o=4; exc_ack_i=1 -> irq_ack_o=4'b0100 for one cycle, busy_o=1; eret_i -> IDLE, estatus_o=0.
REQ-035 irq_i[3] and irq_i[1] rise in the same cycle -> channel 1 served first (estatus=3); after eret, channel 3 served (estatus=5) without a new edge.
REQ-036 mask=4'b1110, irq_i[0] rises -> no exc_o; write mask=4'b1111 -> exc_o asserts, estatus_o=2.
REQ-037 exc_i and irq_i[0] edge in the same cycle -> estatus_o=1, irq_ack_o=0 on ack; channel 0 is served after eret.
REQ-038 exc_i pulsed during HANDLER -> fault_o=1 and remains 1 through eret until reset; estatus unchanged.
REQ-039 Reset pulsed while in REQ -> all outputs 0, mask=all ones, pending cleared, no irq_ack_o pulse.
